// File: rtl/mix_columns_enc.sv
// mix_columns_enc: iterative AES MixColumns / InvMixColumns engine.
// Accepts a 128-bit state and transforms one 32-bit column per cycle, in place.
// A result appears four edges after the accept and is held until it is taken.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   state_in / inv valid
//   in_ready   idle, can accept a new state
//   state_in   input state; byte k = state_in[127-8k -: 8], column c = bytes 4c..4c+3
//   inv        0 = MixColumns, 1 = InvMixColumns (sampled on accept)
//   out_valid  state_out holds a completed result
//   out_ready  downstream takes the result
//   state_out  working register, same byte layout as state_in
//   busy       high whenever not idle
//
// Build option: define MIX_COLUMNS_INV_EN to honour inv. Without it, inv is
// ignored, the mode is tied to forward and no inverse multipliers exist.
module mix_columns_enc (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   work_q, work_d;
  logic [31:0]    col_word, col_mixed;
  logic           mode_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic mode_d;

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    {a[0], a[1], a[2], a[3]} = c;
    for (int i = 0; i < 4; i++) begin
      x2 = xtime(a[i]);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign col_mixed = mode_q ? mix_inv(col_word) : mix_fwd(col_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign mode_q     = 1'b0;
  assign col_mixed  = mix_fwd(col_word);
`endif

  always_comb begin
    col_word = 32'h0;
    unique case (col_q)
      2'd0: col_word = work_q[127:96];
      2'd1: col_word = work_q[95:64];
      2'd2: col_word = work_q[63:32];
      2'd3: col_word = work_q[31:0];
      default: col_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
`ifdef MIX_COLUMNS_INV_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = state_in;
`ifdef MIX_COLUMNS_INV_EN
          mode_d  = inv;
`endif
          col_d   = 2'd0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        unique case (col_q)
          2'd0: work_d[127:96] = col_mixed;
          2'd1: work_d[95:64]  = col_mixed;
          2'd2: work_d[63:32]  = col_mixed;
          2'd3: work_d[31:0]   = col_mixed;
          default: work_d = work_q;
        endcase
        // Wraps to 0 after the last column.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= 2'd0;
      work_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_enc.sv
module tb_mix_columns_enc;

`ifdef MIX_COLUMNS_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int checks = 0;
  int passed = 0;

  mix_columns_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .inv       (inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Generic GF(2^8) shift-and-add multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product applied to every column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic use_inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r = 128'h0;
    if (use_inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(base[(j - row + 4) % 4], s[127 - 8 * (4 * c + j) -: 8]);
        r[127 - 8 * (4 * c + row) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction; hold = cycles of backpressure after out_valid rises.
  task automatic do_op(input string tag, input logic [127:0] din, input logic m,
                       input logic [127:0] known, input bit use_known, input int hold);
    logic [127:0] exp;
    int lat;
    exp = use_known ? known : ref_mix(din, m & InvEn);
    check({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    state_in = din;
    inv      = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = rnd128();
    inv      = ~m;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, lat, 4);
    check({tag, " busy"}, busy, 1);
    check({tag, " result"}, state_out, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = $urandom_range(0, 1);
      state_in = rnd128();
      inv      = $urandom_range(0, 1);
      @(posedge clk); #1;
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold data"}, state_out, exp);
      check({tag, " hold in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drained"}, out_valid, 0);
    check({tag, " idle"}, in_ready, 1);
  endtask

  localparam logic [127:0] V29In  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V29Out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V30In  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V30Out = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  initial begin
    logic [127:0] exp_b2b [2];
    logic [127:0] din_b [2];
    logic         m_b [2];
    int acc_cyc [2];
    int nacc, nres;

    rst_n = 1'b0; in_valid = 1'b0; state_in = '0; inv = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset state_out", state_out, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vectors: the reference model is checked against them too.
    check("model fwd", ref_mix(V29In, 1'b0), V29Out);
    check("model inv", ref_mix(V29Out, 1'b1), V29In);
    do_op("v29", V29In, 1'b0, V29Out, 1'b1, 0);
    do_op("v30", V30In, 1'b0, V30Out, 1'b1, 0);
    do_op("v31", V29Out, 1'b1, InvEn ? V29In : ref_mix(V29Out, 1'b0), 1'b1, 0);
    do_op("bp", rnd128(), 1'b0, '0, 1'b0, 10);
    check("bp busy after", busy, 0);

    for (int i = 0; i < 6; i++)
      do_op($sformatf("rnd%0d", i), rnd128(), 1'($urandom_range(0, 1)), '0, 1'b0,
            $urandom_range(0, 3));

    // Reset two edges into CALC.
    in_valid = 1'b1; state_in = rnd128(); inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst mid out_valid", out_valid, 0);
    check("rst mid state_out", state_out, 128'h0);
    check("rst mid busy", busy, 0);
    check("rst mid in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post rst", V29In, 1'b0, V29Out, 1'b1, 0);

    // Back-to-back with in_valid and out_ready held high.
    for (int k = 0; k < 2; k++) begin
      din_b[k] = rnd128();
      m_b[k]   = 1'($urandom_range(0, 1));
      exp_b2b[k] = ref_mix(din_b[k], m_b[k] & InvEn);
    end
    nacc = 0; nres = 0; acc_cyc[0] = -100; acc_cyc[1] = 100;
    in_valid = 1'b1; out_ready = 1'b1; state_in = din_b[0]; inv = m_b[0];
    for (int c = 0; c < 40 && nres < 2; c++) begin
      if (out_valid) begin
        check($sformatf("b2b result%0d", nres), state_out, exp_b2b[nres]);
        nres++;
      end
      if (in_ready && in_valid && nacc < 2) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk); #1;
      if (nacc == 1) begin state_in = din_b[1]; inv = m_b[1]; end
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b results seen", nres, 2);
    check("b2b spacing", acc_cyc[1] - acc_cyc[0], 6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
